// File: rtl/rf_fifo_ctrl_pkg.sv
// Shared NoC buffer constants and the read-issue room test used by the
// register-file FIFO controller.
package rf_fifo_ctrl_pkg;

  localparam int FLIT_WIDTH = 16;
  localparam int BUF_DEPTH  = 32;
  localparam int BUF_AW     = 5;

  // True when the skid can absorb one more returning read, given its
  // occupancy, a read already in flight, and a pop happening this cycle.
  function automatic logic skid_has_room(input logic [1:0] skid_cnt,
                                         input logic       pending,
                                         input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, skid_cnt} + {2'b00, pending} - {2'b00, pop};
    return (occ < 3'd2);
  endfunction

endpackage

// File: rtl/rf_fifo_skid.sv
// Two-entry output skid buffer; entry 0 is always the head.
module rf_fifo_skid
  import rf_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = FLIT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] e0;
  logic [WIDTH-1:0] e1;
  logic [1:0]       cnt;
  logic             pop_ok;

  assign pop_ok = pop && (cnt != 2'd0);
  assign count  = cnt;
  // Head reads zero while empty so stale entries never leak onto out_data.
  assign head   = (cnt != 2'd0) ? e0 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= push_data;
          end else begin
            e0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rf_fifo_ctrl.sv
// FIFO controller around the registered register-file RAM: writes flits in
// order, issues reads, and re-times the one-shot RAM output through a skid.
module rf_fifo_ctrl
  import rf_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH    = FLIT_WIDTH,
  parameter int DEPTH    = BUF_DEPTH,
  parameter int ADDWIDTH = BUF_AW
) (
  input  logic                clk,
  input  logic                reset,
  // valid/ready on both sides: a beat moves on a rising edge where the
  // sender's valid and the receiver's ready are both high.
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  input  logic                out_ready,
  output logic [ADDWIDTH:0]   level,
  output logic                rf_we,
  output logic [ADDWIDTH-1:0] rf_dest,
  output logic [WIDTH-1:0]    rf_din,
  output logic                rf_re,
  output logic [ADDWIDTH-1:0] rf_source,
  input  logic [WIDTH-1:0]    rf_dout
);

  localparam logic [ADDWIDTH:0] CNT_FULL = (ADDWIDTH+1)'(DEPTH);

  logic [ADDWIDTH-1:0] wr_ptr;
  logic [ADDWIDTH-1:0] rd_ptr;
  logic [ADDWIDTH:0]   cnt;
  logic                pending;
  logic [1:0]          skid_cnt;
  logic                pop;

  assign in_ready  = (cnt != CNT_FULL);
  assign rf_we     = in_valid && in_ready;
  assign rf_dest   = wr_ptr;
  assign rf_din    = in_data;

  assign out_valid = (skid_cnt != 2'd0);
  assign pop       = out_valid && out_ready;

  // Only issue when the skid is guaranteed a free slot for the return beat,
  // since the RAM drives zero on the cycle after the data appears.
  assign rf_re     = (cnt != '0) && skid_has_room(skid_cnt, pending, pop);
  assign rf_source = rd_ptr;

  assign level = cnt + (ADDWIDTH+1)'(pending) + (ADDWIDTH+1)'(skid_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (rf_we) wr_ptr <= wr_ptr + 1'b1;
      if (rf_re) rd_ptr <= rd_ptr + 1'b1;
      pending <= rf_re;
      case ({rf_we, rf_re})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  rf_fifo_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (pending),
    .push_data (rf_dout),
    .pop       (pop),
    .head      (out_data),
    .count     (skid_cnt)
  );

endmodule
